pc_fetch_unit: RTL and testbench

Fetch-stage program counter owner for the MIPS pipeline. Holds the architectural PC, drives the instruction-memory request handshake and publishes PC+4 to the branch-target adder. Consumes the adder's branch target (and jump target) to redirect fetch, and flushes the IF/ID slot on redirect. Sits between the hazard/branch-resolution logic and instruction memory.

---
 rtl/mips_pkg.sv | 12 +
 rtl/pc_next_sel.sv | 29 ++
 rtl/pc_fetch_unit.sv | 96 +++++++++
 tb/tb_pc_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage constants and the fetch FSM state encoding for the MIPS pipeline.
package mips_pkg;
    localparam int PC_WIDTH = 10;
    localparam logic [PC_WIDTH-1:0] RESET_PC = 10'h000;
    localparam logic [PC_WIDTH-1:0] PC_INC   = 10'd4;

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetchState_t;
endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for the next fetch PC: jump, then branch, then stall-hold, then sequential advance.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] pcPlus4,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jumpTarget,
    input  logic                branchTaken,
    input  logic [PC_WIDTH-1:0] branchTarget,
    input  logic                stall,
    input  logic                transfer,
    output logic [PC_WIDTH-1:0] nextPc,
    output logic                redirect
);
    always_comb begin
        nextPc   = pc;
        redirect = 1'b0;
        if (jump) begin
            nextPc   = jumpTarget;
            redirect = 1'b1;
        end else if (branchTaken) begin
            nextPc   = branchTarget;
            redirect = 1'b1;
        end else if (!stall && transfer) begin
            nextPc = pcPlus4;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC owner: START/FETCH/HALTED FSM, imem request handshake, IF/ID valid and flush.
module pc_fetch_unit
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    input  logic                halt_i,
    input  logic                imem_ready_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_plus4_o,
    output logic                if_valid_o,
    output logic                flush_o,
    output fetchState_t         stateDbg
);
    // Handshake: a request completes in any cycle where imem_req_o and imem_ready_i are both
    // high; the address may move while waiting, memory samples it only when ready.
    fetchState_t         state;
    logic [PC_WIDTH-1:0] pcReg;
    logic [PC_WIDTH-1:0] pcPlus4;
    logic [PC_WIDTH-1:0] nextPc;
    logic                redirect;
    logic                transfer;
    logic                reqReg;
    logic                ifValid;
    logic                flush;

    assign pcPlus4     = pcReg + PC_INC;
    assign transfer    = reqReg & imem_ready_i;
    assign pc_o        = pcReg;
    assign imem_addr_o = pcReg;
    assign pc_plus4_o  = pcPlus4;
    assign imem_req_o  = reqReg;
    assign if_valid_o  = ifValid;
    assign flush_o     = flush;
    assign stateDbg    = state;

    pc_next_sel uNextSel (
        .pc           (pcReg),
        .pcPlus4      (pcPlus4),
        .jump         (jump_i),
        .jumpTarget   (jump_target_i),
        .branchTaken  (branch_taken_i),
        .branchTarget (branch_target_i),
        .stall        (stall_i),
        .transfer     (transfer),
        .nextPc       (nextPc),
        .redirect     (redirect)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= START;
            pcReg   <= RESET_PC;
            reqReg  <= 1'b0;
            ifValid <= 1'b0;
            flush   <= 1'b0;
        end else begin
            case (state)
                START: begin
                    state   <= FETCH;
                    reqReg  <= 1'b1;
                    ifValid <= 1'b0;
                    flush   <= 1'b0;
                end
                FETCH: begin
                    pcReg <= nextPc;
                    flush <= redirect;
                    if (redirect)     ifValid <= 1'b0;
                    else if (stall_i) ifValid <= ifValid;
                    else              ifValid <= transfer;
                    // A halt still lets this cycle's redirect or advance land first.
                    if (halt_i) begin
                        state  <= HALTED;
                        reqReg <= 1'b0;
                    end
                end
                HALTED: begin
                    reqReg  <= 1'b0;
                    ifValid <= 1'b0;
                    flush   <= 1'b0;
                end
                default: begin
                    state  <= START;
                    reqReg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;
    import mips_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stall_i = 1'b0;
    logic                branch_taken_i = 1'b0;
    logic [PC_WIDTH-1:0] branch_target_i = '0;
    logic                jump_i = 1'b0;
    logic [PC_WIDTH-1:0] jump_target_i = '0;
    logic                halt_i = 1'b0;
    logic                imem_ready_i = 1'b1;
    logic                imem_req_o;
    logic [PC_WIDTH-1:0] imem_addr_o;
    logic [PC_WIDTH-1:0] pc_o;
    logic [PC_WIDTH-1:0] pc_plus4_o;
    logic                if_valid_o;
    logic                flush_o;
    fetchState_t         stateDbg;

    int checksTotal  = 0;
    int checksPassed = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .halt_i          (halt_i),
        .imem_ready_i    (imem_ready_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .if_valid_o      (if_valid_o),
        .flush_o         (flush_o),
        .stateDbg        (stateDbg)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checksTotal++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            checksPassed++;
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectCore(input string tag, input logic [PC_WIDTH-1:0] pc,
                              input logic req, input logic ifv, input logic fl);
        checkVal({tag, ".pc"}, 32'(pc_o), 32'(pc));
        checkVal({tag, ".addr"}, 32'(imem_addr_o), 32'(pc));
        checkVal({tag, ".req"}, 32'(imem_req_o), 32'(req));
        checkVal({tag, ".ifv"}, 32'(if_valid_o), 32'(ifv));
        checkVal({tag, ".flush"}, 32'(flush_o), 32'(fl));
    endtask

    initial begin
        #2;
        expectCore("reset", 10'h000, 1'b0, 1'b0, 1'b0);
        checkVal("reset.plus4", 32'(pc_plus4_o), 32'h004);
        checkVal("reset.state", 32'(stateDbg), 32'(START));

        // Release reset away from the edge, then START for one cycle.
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkVal("start.state", 32'(stateDbg), 32'(FETCH));
        expectCore("firstReq", 10'h000, 1'b1, 1'b0, 1'b0);

        // Sequential fetch with ready held high.
        for (int i = 1; i <= 4; i++) begin
            step();
            expectCore($sformatf("seq%0d", i), PC_WIDTH'(i * 4), 1'b1, 1'b1, 1'b0);
        end

        // Memory not ready for three cycles at 0x010.
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expectCore($sformatf("wait%0d", i), 10'h010, 1'b1, 1'b0, 1'b0);
        end
        imem_ready_i = 1'b1;
        step();
        expectCore("afterWait", 10'h014, 1'b1, 1'b1, 1'b0);

        // Branch taken wins over stall.
        stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 10'h120;
        step();
        expectCore("brStall", 10'h120, 1'b1, 1'b0, 1'b1);
        stall_i = 1'b0; branch_taken_i = 1'b0;
        step();
        expectCore("brAfter", 10'h124, 1'b1, 1'b1, 1'b0);

        // Jump has priority over a simultaneous branch.
        jump_i = 1'b1; jump_target_i = 10'h200; branch_taken_i = 1'b1; branch_target_i = 10'h120;
        step();
        expectCore("jmpBr", 10'h200, 1'b1, 1'b0, 1'b1);
        jump_i = 1'b0; branch_taken_i = 1'b0;
        step();
        expectCore("jmpBrAfter", 10'h204, 1'b1, 1'b1, 1'b0);

        // Back-to-back redirects, the second landing at the top of the address space.
        jump_i = 1'b1; jump_target_i = 10'h300;
        step();
        expectCore("b2b0", 10'h300, 1'b1, 1'b0, 1'b1);
        jump_target_i = 10'h3FC;
        step();
        expectCore("b2b1", 10'h3FC, 1'b1, 1'b0, 1'b1);
        checkVal("wrap.plus4Top", 32'(pc_plus4_o), 32'h000);
        jump_i = 1'b0;
        step();
        expectCore("wrap", 10'h000, 1'b1, 1'b1, 1'b0);
        checkVal("wrap.plus4", 32'(pc_plus4_o), 32'h004);

        // Plain stall holds PC and the valid slot.
        stall_i = 1'b1;
        step();
        expectCore("stall", 10'h000, 1'b1, 1'b1, 1'b0);
        stall_i = 1'b0;

        // Move to 0x040 and halt there with no transfer in the halt cycle.
        jump_i = 1'b1; jump_target_i = 10'h040;
        step();
        expectCore("toHalt", 10'h040, 1'b1, 1'b0, 1'b1);
        jump_i = 1'b0; halt_i = 1'b1; imem_ready_i = 1'b0;
        step();
        checkVal("halt.state", 32'(stateDbg), 32'(HALTED));
        expectCore("halt", 10'h040, 1'b0, 1'b0, 1'b0);
        halt_i = 1'b0; imem_ready_i = 1'b1;
        jump_i = 1'b1; jump_target_i = 10'h200; branch_taken_i = 1'b1; stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            expectCore($sformatf("halted%0d", i), 10'h040, 1'b0, 1'b0, 1'b0);
        end
        jump_i = 1'b0; branch_taken_i = 1'b0; stall_i = 1'b0;

        // Asynchronous reset between clock edges.
        rst_n = 1'b0;
        #1;
        expectCore("asyncRst", 10'h000, 1'b0, 1'b0, 1'b0);
        checkVal("asyncRst.state", 32'(stateDbg), 32'(START));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        expectCore("restart", 10'h000, 1'b1, 1'b0, 1'b0);
        step();
        expectCore("restartSeq", 10'h004, 1'b1, 1'b1, 1'b0);

        // Halt together with a jump: jump lands, then HALTED.
        halt_i = 1'b1; jump_i = 1'b1; jump_target_i = 10'h080;
        step();
        checkVal("haltJmp.state", 32'(stateDbg), 32'(HALTED));
        expectCore("haltJmp", 10'h080, 1'b0, 1'b0, 1'b1);
        halt_i = 1'b0; jump_i = 1'b0;
        step();
        expectCore("haltJmpAfter", 10'h080, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
